// File: rtl/register_file_mp.sv
// Multi-ported MIPS register file: parallel writes, read bypass,
// hardwired zero register and a pending-write scoreboard.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_DEPTH   = 2,
  parameter int WR_DEPTH   = 2,
  parameter int REG_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WR_DEPTH-1:0]            wr,
  input  logic [ADDR_WIDTH*WR_DEPTH-1:0] rw,
  input  logic [DATA_WIDTH*WR_DEPTH-1:0] d,
  input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
  output logic [DATA_WIDTH*RD_DEPTH-1:0] q,
  input  logic                           rsv,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic [RD_DEPTH-1:0]            pend,
  output logic                           pend_any
);

  localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

  logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [REG_DEPTH-1:0]                 sb_q, sb_d;

  // Later ports overwrite earlier ones; reserve is applied last so it wins.
  always_comb begin
    regs_d = regs_q;
    sb_d   = sb_q;
    for (int i = 0; i < WR_DEPTH; i++) begin
      if (wr[i] && rw[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO) begin
        regs_d[rw[i*ADDR_WIDTH +: ADDR_WIDTH]] = d[i*DATA_WIDTH +: DATA_WIDTH];
        sb_d[rw[i*ADDR_WIDTH +: ADDR_WIDTH]]   = 1'b0;
      end
    end
    if (rsv && rsv_addr != ZERO) begin
      sb_d[rsv_addr] = 1'b1;
    end
    regs_d[0] = '0;
    sb_d[0]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      sb_q   <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
    end
  end

  for (genvar j = 0; j < RD_DEPTH; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rv;

    assign ra = rr[j*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rv = regs_q[ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < WR_DEPTH; i++) begin
          if (wr[i] && rw[i*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
            rv = d[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      // Bypass must not leak through during reset or for r0.
      if (ra == ZERO || !rst) begin
        rv = '0;
      end
    end

    assign q[j*DATA_WIDTH +: DATA_WIDTH] = rv;
    assign pend[j] = rst && (ra != ZERO) && sb_q[ra];
  end

  assign pend_any = rst && (|sb_q);

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Multi-ported MIPS register file, successor to the single-write register_file. Adds:
- WR_DEPTH parallel write ports with a fixed collision priority
- Same-cycle write-to-read bypass
- Hardwired-zero register 0
- A pending-write scoreboard for pipeline hazard detection

Sits between decode (read ports, reserve) and writeback (write ports) in the CPU datapath.

Parameters:
DATA_WIDTH, 32, word length in bits
RD_DEPTH, 2, number of parallel read ports
WR_DEPTH, 2, number of parallel write ports
REG_DEPTH, 32, number of registers; must equal 2**ADDR_WIDTH
ADDR_WIDTH, 5, register address width
BYPASS, 1, 1 = a read of an address written this cycle returns the write data; 0 = returns the stored value

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
wr  input  WR_DEPTH  per-port write enable; bit i belongs to write port i
rw  input  ADDR_WIDTH*WR_DEPTH  vectorized write addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
d  input  DATA_WIDTH*WR_DEPTH  vectorized write data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
rr  input  ADDR_WIDTH*RD_DEPTH  vectorized read addresses; port j at [j*ADDR_WIDTH +: ADDR_WIDTH]
q  output  DATA_WIDTH*RD_DEPTH  vectorized read data; port j at [j*DATA_WIDTH +: DATA_WIDTH]
rsv  input  1  reserve: mark register rsv_addr as pending
rsv_addr  input  ADDR_WIDTH  register to reserve
pend  output  RD_DEPTH  bit j = 1 when the register addressed by rr port j is pending
pend_any  output  1  OR of the entire scoreboard

Behaviour:
- Reset: rst low clears all registers to 0 and all scoreboard bits to 0 immediately, regardless of clk. While rst is low: q = 0, pend = 0, pend_any = 0. Writes and reserves are ignored. Reset asserted mid-write discards that write. First write is accepted on the first rising edge after rst deasserts.
- Write: on rising edge, for each port i with wr[i]=1 and address != 0, reg[rw_i] <= d_i.
- Write collision: several ports writing the same address in one cycle → the highest-index port wins. Lower ports to that address are dropped. No error flag.
- Register 0: writes to address 0 are ignored. Reads of address 0 always return 0, bypass included. Scoreboard bit 0 is never set; a reserve of address 0 is a no-op.
- Read: combinational, zero latency. q_j = reg[rr_j].
- Bypass, BYPASS=1: if any port i has wr[i]=1 and rw_i == rr_j != 0 in the current cycle, q_j = d_i from the highest such i.
- Bypass, BYPASS=0: q_j shows the new value only after the edge, i.e. one cycle after the write.
- Scoreboard, one bit per register:
  - Set on the rising edge when rsv=1 and rsv_addr != 0.
  - Cleared on the rising edge when any port writes that address.
  - Reserve and write to the same address in one cycle → reserve wins; the bit stays 1, representing a newer outstanding producer.
- Scoreboard is not bypassed against same-cycle writes. pend reflects state before the edge. Decode treats a same-cycle write as the hazard resolving.
- pend_j: combinational from the scoreboard and rr_j. Always 0 for address 0.
- Arithmetic: no arithmetic on data. Widths are exact; no truncation or extension.
- Out-of-range addresses cannot occur because REG_DEPTH = 2**ADDR_WIDTH. A mismatched configuration is a parameter error.

Test Plan:
1. Reset, then rr={5'd27,5'd4} → q=0, pend=0, pend_any=0. Assert rst low mid-cycle with wr[0]=1, rw0=3, d0=32'h11111111 → reg3 still 0 after release.
2. wr=2'b01, rw0=27, d0=32'hdcaf484c, one edge; then rr port0=27 → q0=32'hdcaf484c. Write rw0=0, d0=32'hffffffff → read of 0 returns 0.
3. Same cycle: wr=2'b11, rw0=rw1=4, d0=32'h37373737, d1=32'h12345678 → after the edge, reg4=32'h12345678.
4. BYPASS=1: rr port1=9, wr[0]=1, rw0=9, d0=32'hcafef00d → q1=32'hcafef00d before the edge. BYPASS=0 instance: q1 shows the old value (0) until after the edge.
5. rsv=1, rsv_addr=8, one edge; rr port0=8 → pend[0]=1, pend_any=1. Write port1 to 8 → pend[0]=0 after the edge, pend_any=0.
6. In one cycle: rsv=1, rsv_addr=6 and wr[0]=1, rw0=6 → after the edge reg6 is updated and pend for 6 = 1. rsv_addr=0 → pend_any stays 0.
